seg_display_scanner: RTL

- Time-multiplexes a 32-bit hex value onto the Nexys4 eight-digit common-anode 7-segment display.
- Sequences digit anodes, selects the active nibble, and drives the shared nibble-to-segment decoder.
- Sits between the processor's debug/output register and the board pins.
- Inserts a blanking gap between digits against ghosting; swaps the displayed value only at frame boundaries so no tearing is visible.

---
 rtl/seg_disp_pkg.sv | 35 +++
 rtl/seg_nibble_decoder.sv | 11 +
 rtl/seg_display_scanner.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the 7-segment display scanner: scan states,
// active-low segment code table ({a,b,c,d,e,f,g}) and blink period.
package seg_disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Frames per blink phase when the blink option is built in.
  localparam int BLINK_FRAMES = 32;

  // Indexed by nibble value; entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/seg_nibble_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern, shared by all digits.
module seg_nibble_decoder
  import seg_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed hex scanner for a common-anode multi-digit 7-segment display
// with blanking gap, frame-aligned load and leading-zero blanking.
// Optional per-digit blinking is built in when SEG_DISPLAY_BLINK_EN is defined.
module seg_display_scanner
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load_req,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lzb_en,
`ifdef SEG_DISPLAY_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic                    load_ack,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n
);

  localparam int TICK_W = $clog2(DIGIT_TICKS);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_TICKS);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] tick_next;
  logic [IDX_W-1:0]  idx;
  logic              slot_end;
  logic              frame_end;

  scan_state_e state;
  scan_state_e state_next;

  logic [4*NUM_DIGITS-1:0]     display_q;
  logic [4*NUM_DIGITS-1:0]     pend_data;
  logic                        pend_valid;
  logic [NUM_DIGITS-1:0][3:0]  digits;
  logic [NUM_DIGITS-1:0]       zero_run;
  logic [3:0]                  nibble;
  logic [6:0]                  seg_code;
  logic                        digit_blank;
  logic                        blink_off;

  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  // Slot timing
  assign slot_end  = (tick == TICK_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign tick_next = slot_end ? '0 : tick + 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its inputs regardless of statement order.
    if (!rst_n) begin
      tick <= '0;
      idx  <= '0;
    end else begin
      tick <= tick_next;
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Load handshake: pending holds the newest request until the frame boundary,
  // so the visible value only ever changes between frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display_q  <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      load_ack   <= frame_end && (pend_valid || load_req);
      if (frame_end) begin
        if (load_req) begin
          display_q <= data_in;
        end else if (pend_valid) begin
          display_q <= pend_data;
        end
        pend_valid <= 1'b0;
      end else if (load_req) begin
        pend_data  <= data_in;
        pend_valid <= 1'b1;
      end
    end
  end

  // Digit data path and leading-zero detection
  assign digits = display_q;
  assign nibble = digits[idx];

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_run[i] = ((display_q >> (4 * i)) == '0);
    end
  end

  assign digit_blank = lzb_en && (idx != '0) && zero_run[idx];

  seg_nibble_decoder u_decoder (
    .nibble (nibble),
    .seg_n  (seg_code)
  );

`ifdef SEG_DISPLAY_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [BLINK_W-1:0] frame_cnt;
  logic               blink_on;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_off = !blink_on && blink_mask[idx];
`else
  assign blink_off = 1'b0;
`endif

  // Scan FSM: state tracks the slot phase of the current tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BLANK;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_next = (tick_next < TICK_BLANK) ? BLANK : DRIVE;
    an_d       = '1;
    seg_d      = SEG_OFF;
    dp_d       = 1'b1;
    if (state == DRIVE) begin
      an_d[idx] = 1'b0;
      seg_d     = (digit_blank || blink_off) ? SEG_OFF : seg_code;
      dp_d      = blink_off ? 1'b1 : ~dp_mask[idx];
    end
  end

  // Pin registers: one cycle behind tick/idx, glitch-free at the board.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_n  <= '1;
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= an_d;
      seg_n <= seg_d;
      dp_n  <= dp_d;
    end
  end

endmodule
